// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams N operand pairs from two synchronous ROMs into a
// saturating MAC, steers its accumulator controls, and hands off the captured sum.
package definitions;
  parameter int Q_INT  = 8;
  parameter int Q_FRAC = 8;
  parameter int Q_SIZE = Q_INT + Q_FRAC;
endpackage

module mac_sequencer
  import definitions::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  mac_acc_loopback,
  output logic                  mac_acc_update,
  input  logic [Q_SIZE-1:0]     mac_acc,
  output logic [Q_SIZE-1:0]     result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CAPT, S_OUT} state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic                  r_ready;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_x_addr;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [Q_SIZE-1:0]     r_result;
  logic                  r_valid;
  logic                  r_d_valid;
  logic                  r_d_first;
  logic                  w_last;

  // r_idx is the index whose addresses are on the bus this cycle
  assign w_last = (r_idx == r_len - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_ready   <= 1'b1;
      r_rd_en   <= 1'b0;
      r_x_addr  <= '0;
      r_w_addr  <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_first <= 1'b0;
    end else begin
      // Tags follow the one-cycle memory latency so update lines up with data
      r_d_valid <= r_rd_en;
      r_d_first <= r_rd_en && (r_idx == '0);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_idx   <= '0;
            r_ready <= 1'b0;
            if (len == '0) begin
              r_result <= '0;
              r_valid  <= 1'b1;
              r_state  <= S_OUT;
            end else begin
              r_x_addr <= x_base;
              r_w_addr <= w_base;
              r_rd_en  <= 1'b1;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_idx <= r_idx + LEN_WIDTH'(1);
          if (w_last) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_x_addr <= r_x_addr + ADDR_WIDTH'(1);
            r_w_addr <= r_w_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: r_state <= S_CAPT;
        S_CAPT: begin
          r_result <= mac_acc;
          r_valid  <= 1'b1;
          r_state  <= S_OUT;
        end
        S_OUT: begin
          if (result_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready            = r_ready;
  assign rd_en            = r_rd_en;
  assign x_addr           = r_x_addr;
  assign w_addr           = r_w_addr;
  assign result           = r_result;
  assign result_valid     = r_valid;
  // First term overwrites the accumulator so earlier commands never leak in
  assign mac_acc_update   = r_d_valid;
  assign mac_acc_loopback = r_d_valid & ~r_d_first;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with ROM and saturating Q8.8 MAC models.
module tb_mac_sequencer;
  import definitions::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              ready;
  logic [7:0]        len;
  logic [7:0]        x_base;
  logic [7:0]        w_base;
  logic              rd_en;
  logic [7:0]        x_addr;
  logic [7:0]        w_addr;
  logic              mac_acc_loopback;
  logic              mac_acc_update;
  logic [Q_SIZE-1:0] mac_acc;
  logic [Q_SIZE-1:0] result;
  logic              result_valid;
  logic              result_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .len(len),
    .x_base(x_base), .w_base(w_base), .rd_en(rd_en), .x_addr(x_addr),
    .w_addr(w_addr), .mac_acc_loopback(mac_acc_loopback),
    .mac_acc_update(mac_acc_update), .mac_acc(mac_acc), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  // Synchronous ROMs and a saturating Q8.8 MAC
  logic [15:0]        xmem [0:255];
  logic [15:0]        wmem [0:255];
  logic signed [15:0] xd, wd;
  logic signed [15:0] acc = 16'sh1234;

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      xd <= xmem[x_addr];
      wd <= wmem[w_addr];
    end
    if (mac_acc_update)
      acc <= sat16((mac_acc_loopback ? longint'(acc) : 64'sd0) +
                   ((longint'(xd) * longint'(wd)) >>> 8));
  end
  assign mac_acc = acc;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {ready, rd_en, x_addr, w_addr, mac_acc_loopback, mac_acc_update,
                result, result_valid},
               {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0});
  endtask

  // Issue one command, wait (bounded) for valid, then complete the handshake
  task automatic run_cmd(input logic [7:0] n, input logic [7:0] xb, input logic [7:0] wb,
                         output logic [15:0] res, output int lat);
    len = n; x_base = xb; w_base = wb; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!result_valid && lat < 600) begin
      tick();
      lat++;
    end
    res = result;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  logic [7:0]  upd_seen, loop_seen, vld_seen;
  logic [15:0] res, res6;
  int          lat;
  logic        bad;

  initial begin
    for (int a = 0; a < 256; a++) begin xmem[a] = '0; wmem[a] = '0; end
    xmem[0]  = 16'h0100; xmem[1]  = 16'h0200; xmem[2]  = 16'hff80;
    wmem[16] = 16'h0080; wmem[17] = 16'h0040; wmem[18] = 16'h0100;
    xmem[32] = 16'h7fff; xmem[33] = 16'h7fff; wmem[48] = 16'h7fff; wmem[49] = 16'h7fff;
    xmem[40] = 16'h8000; xmem[41] = 16'h8000; wmem[56] = 16'h7fff; wmem[57] = 16'h7fff;
    xmem[64] = 16'h0100; xmem[65] = 16'h0200; wmem[80] = 16'h0100; wmem[81] = 16'h0100;
    xmem[66] = 16'h0100; wmem[82] = 16'hff00;
    xmem[100] = 16'h0100; wmem[110] = 16'h0100;
    for (int a = 120; a < 128; a++) begin xmem[a] = 16'h0100; wmem[a+20] = 16'h0100; end
    xmem[200] = 16'h0200; wmem[210] = 16'h0200;

    rst = 1'b1; start = 1'b0; len = '0; x_base = '0; w_base = '0; result_ready = 1'b0;
    tick(); tick();
    check_reset_outs("reset_state");
    rst = 1'b0;
    tick();

    // Basic dot product, ready held high: update cycles 2..4, valid rises in cycle 6
    len = 8'd3; x_base = 8'd0; w_base = 8'd16; result_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    upd_seen = '0; loop_seen = '0; vld_seen = '0; res6 = '0;
    for (int k = 1; k <= 7; k++) begin
      upd_seen[k]  = mac_acc_update;
      loop_seen[k] = mac_acc_loopback;
      vld_seen[k]  = result_valid;
      if (k == 1) check("basic_c1_rd", {ready, rd_en, x_addr, w_addr}, {1'b0, 1'b1, 8'd0, 8'd16});
      if (k == 6) res6 = result;
      if (k == 7) check("basic_c7_ready", ready, 1'b1);
      tick();
    end
    result_ready = 1'b0;
    check("basic_update_cycles", upd_seen, 8'b0001_1100);
    check("basic_loopback_cycles", loop_seen, 8'b0001_1000);
    check("basic_valid_cycles", vld_seen, 8'b0100_0000);
    check("basic_result", res6, 16'h0080);

    run_cmd(8'd2, 8'd32, 8'd48, res, lat);
    check("sat_pos_result", res, 16'h7fff);
    check("sat_pos_latency", lat, 5);
    run_cmd(8'd2, 8'd40, 8'd56, res, lat);
    check("sat_neg_result", res, 16'h8000);

    run_cmd(8'd2, 8'd64, 8'd80, res, lat);
    check("stale_first", res, 16'h0300);
    run_cmd(8'd1, 8'd66, 8'd82, res, lat);
    check("stale_second", res, 16'hff00);
    check("stale_latency", lat, 4);

    // Zero length: valid in cycle 1, result forced to 0, no reads
    len = 8'd0; x_base = 8'd5; w_base = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_c1", {result_valid, result, rd_en, mac_acc_update}, {1'b1, 16'h0000, 1'b0, 1'b0});
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("zero_ready_after", {ready, result_valid}, {1'b1, 1'b0});

    // Address wrap
    len = 8'd4; x_base = 8'd254; w_base = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_addr_%0d", k), {rd_en, x_addr, w_addr},
            {1'b1, 8'(254 + k), 8'(10 + k)});
      tick();
    end
    check("wrap_rd_off", rd_en, 1'b0);
    lat = 0;
    while (!result_valid && lat < 50) begin tick(); lat++; end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Backpressure with start pulsed during OUT
    len = 8'd1; x_base = 8'd100; w_base = 8'd110; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!result_valid && lat < 50) begin tick(); lat++; end
    check("bp_latency", lat, 4);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3 || k == 7);
      len = 8'd5;
      if (!(result_valid === 1'b1 && result === 16'h0100 && ready === 1'b0 && rd_en === 1'b0))
        bad = 1'b1;
      tick();
    end
    start = 1'b0;
    check("bp_hold_stable", bad, 1'b0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("bp_release", {ready, result_valid}, {1'b1, 1'b0});
    tick();
    check("bp_still_idle", {ready, rd_en}, {1'b1, 1'b0});

    // Reset in cycle 3 of an N=8 run, then a fresh command
    len = 8'd8; x_base = 8'd120; w_base = 8'd140; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("rstmid_update_before", mac_acc_update, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outs("rstmid_outputs");
    tick();
    rst = 1'b0;
    tick();
    run_cmd(8'd1, 8'd200, 8'd210, res, lat);
    check("rstmid_next_result", res, 16'h0400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
